mem_port_arbiter: RTL and testbench

- Shares one unified, multi-cycle, single-port memory between two requesters: the IF stage (instruction read) and the MEM stage (data load/store).
- Grants one requester at a time and drives the memory-side request/ack handshake.
- Returns read data and a one-cycle done pulse to the granted requester.
- Raises per-stage stall signals so the pipeline freezes while an access is outstanding.
- Sits between the stage modules and the shared memory model; replaces direct stage-to-memory wiring.

---
 rtl/mem_port_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a shared single-port multi-cycle memory.
// IF and MEM stages share one port; data wins ties unless IF has been starved.
module mem_port_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_done,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack
);

  // state  | meaning
  // IDLE   | arbitrate between pending requesters
  // D_BUSY | data access outstanding, waiting for m_ack
  // I_BUSY | instruction fetch outstanding, waiting for m_ack
  // RESP   | done pulse to the winner; requests ignored
  typedef enum logic [1:0] {IDLE, D_BUSY, I_BUSY, RESP} state_e;

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  state_e            state_q;
  logic [2:0]        starve_q;
  logic              m_req_q;
  logic              m_we_q;
  logic [ADDR_W-1:0] m_addr_q;
  logic [DATA_W-1:0] m_wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] mem_rdata_q;
  logic              if_done_q;
  logic              mem_done_q;

  logic data_pend;
  logic grant_if;
  logic grant_d;

  always_comb begin
    data_pend = mem_rd | mem_wr;
    grant_if  = if_req & (~data_pend | (starve_q == LIMIT));
    grant_d   = data_pend & ~grant_if;
  end

  assign m_req     = m_req_q;
  assign m_we      = m_we_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign if_done   = if_done_q;
  assign mem_done  = mem_done_q;
  // Combinational so a stage unfreezes in the same cycle as its done pulse.
  assign stall_if  = if_req & ~if_done_q;
  assign stall_mem = data_pend & ~mem_done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      m_req_q     <= 1'b0;
      m_we_q      <= 1'b0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_d) begin
            state_q   <= D_BUSY;
            m_req_q   <= 1'b1;
            m_we_q    <= mem_wr;
            m_addr_q  <= mem_addr;
            m_wdata_q <= mem_wdata;
            if (!if_req)
              starve_q <= '0;
            else if (starve_q != LIMIT)
              starve_q <= starve_q + 3'd1;
          end else if (grant_if) begin
            state_q   <= I_BUSY;
            m_req_q   <= 1'b1;
            m_we_q    <= 1'b0;
            m_addr_q  <= if_addr;
            m_wdata_q <= mem_wdata;
            starve_q  <= '0;
          end
        end
        D_BUSY: begin
          if (m_ack) begin
            state_q    <= RESP;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            mem_done_q <= 1'b1;
            if (!m_we_q)
              mem_rdata_q <= m_rdata;
          end
        end
        I_BUSY: begin
          if (m_ack) begin
            state_q    <= RESP;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            if_done_q  <= 1'b1;
            if_rdata_q <= m_rdata;
          end
        end
        RESP: begin
          state_q    <= IDLE;
          if_done_q  <= 1'b0;
          mem_done_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, scoreboard queues
// and hand-written sequences for arbitration, starvation and reset corners.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        stall_if;
  logic        stall_mem;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ack;

  mem_port_arbiter #(.DATA_W(32), .ADDR_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Memory responder: acks in the ack_delay-th cycle of m_req.
  logic [31:0] mem_model [16];
  logic        mem_init;
  int          ack_delay = 1;
  logic        ack_force;
  int          req_cnt = 0;

  function automatic logic [31:0] init_word(input int i);
    return (i == 1) ? 32'h8C22_0000 : 32'h1000_0000 + 32'(i) * 32'h111;
  endfunction

  always @(posedge clk) begin
    if (m_req && !m_ack) req_cnt <= req_cnt + 1;
    else                 req_cnt <= 0;
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem_model[i] <= init_word(i);
    end else if (m_req && m_ack && m_we) begin
      mem_model[m_addr[5:2]] <= m_wdata;
    end
  end

  assign m_ack   = ack_force | (m_req & (req_cnt == ack_delay - 1));
  assign m_rdata = mem_model[m_addr[5:2]];

  // Scoreboard: expected read-back values per requester.
  logic [31:0] if_q[$];
  logic [31:0] mem_q[$];

  initial begin
    forever begin
      @(negedge clk);
      if (if_done || mem_done)
        chk("dual_done", 32'(if_done & mem_done), 32'd0);
      if (if_done) begin
        if (if_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL spurious_if_done: got done=1 expected no pending fetch");
        end else chk("if_rdata", if_rdata, if_q.pop_front());
      end
      if (mem_done) begin
        if (mem_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL spurious_mem_done: got done=1 expected no pending access");
        end else chk("mem_rdata", mem_rdata, mem_q.pop_front());
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          is_if;
    bit          is_st;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          dly;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs [8];

  task automatic run_vec(input vec_t v);
    int  n;
    int  req_cycles;
    bit  got;
    logic done, stall;
    @(posedge clk); #1;
    ack_delay = v.dly;
    if (v.is_if) begin
      if_addr = v.addr; if_req = 1'b1;
      if_q.push_back(v.exp_data);
    end else begin
      mem_addr = v.addr; mem_wdata = v.wdata;
      mem_wr = v.is_st; mem_rd = !v.is_st;
      mem_q.push_back(v.exp_data);
    end
    n = 0; req_cycles = 0; got = 0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      done  = v.is_if ? if_done : mem_done;
      stall = v.is_if ? stall_if : stall_mem;
      if (m_req) begin
        req_cycles++;
        chk("m_we", 32'(m_we), 32'(!v.is_if && v.is_st));
        chk("m_addr", m_addr, v.addr);
        if (v.is_st) chk("m_wdata", m_wdata, v.wdata);
      end
      chk("stall", 32'(stall), 32'(!done));
      if (done) begin
        got = 1;
        if_req = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
      end
    end
    chk("latency", 32'(n), 32'(v.exp_lat));
    chk("m_req_cycles", 32'(req_cycles), 32'(v.dly));
  endtask

  logic [31:0] ld_addr [5];
  logic [31:0] ld_exp  [5];
  logic        exp_g   [7];
  logic        grants[$];

  initial begin
    int  mem_done_at, if_done_at, cyc, loads_done;
    bit  prev, spurious;

    vecs[0] = '{1, 0, 32'h04, 32'h0,         1, 32'h8C22_0000, 3};
    vecs[1] = '{0, 1, 32'h10, 32'hDEAD_BEEF, 3, 32'h0000_0000, 5};
    vecs[2] = '{0, 0, 32'h10, 32'h0,         1, 32'hDEAD_BEEF, 3};
    vecs[3] = '{0, 0, 32'h08, 32'h0,         2, 32'h1000_0222, 4};
    vecs[4] = '{1, 0, 32'h3C, 32'h0,         4, 32'h1000_0FFF, 6};
    vecs[5] = '{0, 1, 32'h20, 32'h1234_5678, 1, 32'h1000_0222, 3};
    vecs[6] = '{1, 0, 32'h20, 32'h0,         2, 32'h1234_5678, 4};
    vecs[7] = '{0, 0, 32'h00, 32'h0,         1, 32'h1000_0000, 3};
    ld_addr = '{32'h30, 32'h34, 32'h38, 32'h3C, 32'h00};
    ld_exp  = '{32'h1000_0CCC, 32'h1000_0DDD, 32'h1000_0EEE, 32'h1000_0FFF, 32'h1000_0000};
    exp_g   = '{0, 0, 0, 0, 1, 0, 1};

    rst = 1'b1; mem_init = 1'b1; ack_force = 1'b0;
    if_req = 1'b0; if_addr = '0; mem_rd = 1'b0; mem_wr = 1'b0;
    mem_addr = '0; mem_wdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; mem_init = 1'b0;
    @(negedge clk);
    chk("rst_m_req", 32'(m_req), 32'd0);
    chk("rst_m_we", 32'(m_we), 32'd0);
    chk("rst_m_addr", m_addr, 32'd0);
    chk("rst_m_wdata", m_wdata, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_mem_rdata", mem_rdata, 32'd0);
    chk("rst_dones", 32'({if_done, mem_done}), 32'd0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // IF and load in the same IDLE cycle: data first, IF three cycles later.
    @(posedge clk); #1;
    ack_delay = 1;
    if_addr = 32'h04; if_req = 1'b1; if_q.push_back(32'h8C22_0000);
    mem_addr = 32'h08; mem_rd = 1'b1; mem_q.push_back(32'h1000_0222);
    mem_done_at = 0; if_done_at = 0; cyc = 0;
    while (if_done_at == 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (mem_done) begin mem_done_at = cyc; mem_rd = 1'b0; end
      if (if_done)  begin if_done_at = cyc;  if_req = 1'b0; end
    end
    chk("tie_mem_done_at", 32'(mem_done_at), 32'd3);
    chk("tie_if_done_at", 32'(if_done_at), 32'd6);

    // Starvation: IF held pending against five back-to-back loads.
    @(posedge clk); #1;
    if_addr = 32'h04; if_req = 1'b1; if_q.push_back(32'h8C22_0000);
    mem_addr = ld_addr[0]; mem_rd = 1'b1; mem_q.push_back(ld_exp[0]);
    loads_done = 0; prev = 0; cyc = 0;
    while (!(loads_done == 5 && !if_req) && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (m_req && !prev) grants.push_back(m_addr == 32'h04);
      prev = m_req;
      if (mem_done) begin
        loads_done++;
        if (loads_done < 5) begin
          mem_addr = ld_addr[loads_done]; mem_q.push_back(ld_exp[loads_done]);
        end else mem_rd = 1'b0;
      end
      if (if_done) begin
        if (loads_done < 5) if_q.push_back(32'h8C22_0000);
        else                if_req = 1'b0;
      end
    end
    chk("grant_count", 32'(grants.size()), 32'd7);
    for (int i = 0; i < 7 && i < grants.size(); i++)
      chk($sformatf("grant_%0d_is_if", i), 32'(grants[i]), 32'(exp_g[i]));

    // Reset while a load waits for a slow ack.
    @(posedge clk); #1;
    ack_delay = 15;
    mem_addr = 32'h08; mem_rd = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("busy_m_req", 32'(m_req), 32'd1);
    rst = 1'b1; mem_rd = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst2_m_req", 32'(m_req), 32'd0);
    chk("rst2_m_we", 32'(m_we), 32'd0);
    chk("rst2_m_addr", m_addr, 32'd0);
    chk("rst2_m_wdata", m_wdata, 32'd0);
    chk("rst2_if_rdata", if_rdata, 32'd0);
    chk("rst2_mem_rdata", mem_rdata, 32'd0);
    chk("rst2_stall_mem", 32'(stall_mem), 32'd0);
    spurious = 0;
    repeat (20) begin
      @(negedge clk);
      if (m_req || mem_done || if_done) spurious = 1;
    end
    chk("rst2_abandoned", 32'(spurious), 32'd0);

    // Stray ack in IDLE, then a load held high through RESP.
    ack_delay = 1;
    @(posedge clk); #1 ack_force = 1'b1;
    @(posedge clk); #1 ack_force = 1'b0;
    spurious = 0;
    repeat (3) begin
      @(negedge clk);
      if (m_req || mem_done || if_done) spurious = 1;
    end
    chk("idle_ack_ignored", 32'(spurious), 32'd0);
    @(posedge clk); #1;
    mem_addr = 32'h10; mem_rd = 1'b1;
    mem_q.push_back(32'hDEAD_BEEF); mem_q.push_back(32'hDEAD_BEEF);
    @(negedge clk); chk("hold_c1_m_req", 32'(m_req), 32'd0);
    @(negedge clk); chk("hold_c2_m_req", 32'(m_req), 32'd1);
    @(negedge clk); chk("hold_c3_done", 32'(mem_done), 32'd1);
                    chk("hold_c3_m_req", 32'(m_req), 32'd0);
                    chk("hold_c3_stall", 32'(stall_mem), 32'd0);
    @(negedge clk); chk("hold_c4_m_req", 32'(m_req), 32'd0);
                    chk("hold_c4_done", 32'(mem_done), 32'd0);
                    chk("hold_c4_stall", 32'(stall_mem), 32'd1);
    @(negedge clk); chk("hold_c5_m_req", 32'(m_req), 32'd1);
    @(negedge clk); chk("hold_c6_done", 32'(mem_done), 32'd1);
    mem_rd = 1'b0;

    repeat (4) @(negedge clk);
    chk("if_q_empty", 32'(if_q.size()), 32'd0);
    chk("mem_q_empty", 32'(mem_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
